axilite_slave_regs: RTL and testbench

//  AXI4-Lite slave register bank on the action side of the MMIO path; the responder for the
//  AXI-Lite master driven by the MMIO bridge. Decodes 32-bit word accesses into NUM_REGS

---
 rtl/axilite_slave_regs.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axilite_slave_regs.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_regs.sv
// AXI4-Lite slave register bank: CTRL (idx 0, bit0 = start pulse), STATUS (idx 1, RO), general RW above.
// Optional: define AXILITE_SLV_DBG_CNT_EN to expose WR_CNT/RD_CNT at idx NUM_REGS and NUM_REGS+1.
module axilite_slave_regs #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic                   clk_afu,
    input  logic                   rst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [ADDR_W-1:0]      s_axi_awaddr,
    input  logic [2:0]             s_axi_awprot,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic [1:0]             s_axi_bresp,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [ADDR_W-1:0]      s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    input  logic [31:0]            status_in,
    output logic                   ctrl_start,
    output logic [NUM_REGS*32-1:0] regs_out
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned SEL_W = $clog2(NUM_REGS);
    localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    logic [0:0]       w_state_q, w_state_d, r_state_q, r_state_d;
    logic             awready_q, awready_d, wready_q, wready_d;
    logic             bvalid_q, bvalid_d, ctrl_start_q, ctrl_start_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]      regs_q [NUM_REGS];
    logic [31:0]      regs_d [NUM_REGS];

    logic             aw_hs_s, w_hs_s, wr_fire_s, wr_reg_s, wr_dbg_s, wr_err_s, rd_err_s;
    logic [IDX_W-1:0] aw_idx_s, ar_idx_s;
    logic [SEL_W-1:0] aw_sel_s;
    logic [31:0]      wdata_s, rd_val_s;
    logic [3:0]       wstrb_s;
    logic             unused_s;

    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A held channel supplies its captured value; a channel handshaking this cycle supplies the live one.
    assign aw_hs_s   = s_axi_awvalid & awready_q;
    assign w_hs_s    = s_axi_wvalid & wready_q;
    assign aw_idx_s  = aw_hs_s ? s_axi_awaddr[ADDR_W-1:2] : aw_idx_q;
    assign wdata_s   = w_hs_s ? s_axi_wdata : wdata_q;
    assign wstrb_s   = w_hs_s ? s_axi_wstrb : wstrb_q;
    assign wr_fire_s = (w_state_q == W_IDLE) & (aw_hs_s | ~awready_q) & (w_hs_s | ~wready_q);
    assign wr_reg_s  = wr_fire_s & (aw_idx_s < IDX_W'(NUM_REGS));
    assign aw_sel_s  = aw_idx_s[SEL_W-1:0];
    assign ar_idx_s  = s_axi_araddr[ADDR_W-1:2];
`ifdef AXILITE_SLV_DBG_CNT_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;
    assign wr_dbg_s = (aw_idx_s == IDX_W'(NUM_REGS)) | (aw_idx_s == IDX_W'(NUM_REGS + 1));
`else
    assign wr_dbg_s = 1'b0;
`endif
    assign wr_err_s = (aw_idx_s >= IDX_W'(NUM_REGS)) & ~wr_dbg_s;

    // Write channel FSM: collect AW and W in any order, then respond.
    always_comb begin
        w_state_d    = w_state_q;
        awready_d    = awready_q;
        wready_d     = wready_q;
        aw_idx_d     = aw_idx_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        ctrl_start_d = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_idx_d  = s_axi_awaddr[ADDR_W-1:2];
                    awready_d = 1'b0;
                end else begin
                    aw_idx_d  = aw_idx_q;
                end
                if (w_hs_s) begin
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                    wready_d = 1'b0;
                end else begin
                    wdata_d  = wdata_q;
                end
                if (wr_fire_s) begin
                    w_state_d    = W_RESP;
                    awready_d    = 1'b0;
                    wready_d     = 1'b0;
                    bvalid_d     = 1'b1;
                    bresp_d      = wr_err_s ? RESP_SLVERR : RESP_OKAY;
                    ctrl_start_d = wr_reg_s & (aw_sel_s == SEL_W'(0)) & wstrb_s[0] & wdata_s[0];
                end else begin
                    w_state_d    = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Byte-lane merge; CTRL bit0 never stored, STATUS follows status_in.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int k = 0; k < 4; k++) begin
                regs_d[i][8*k +: 8] = (wr_reg_s && (aw_sel_s == SEL_W'(i)) && wstrb_s[k]) ?
                                      wdata_s[8*k +: 8] : regs_q[i][8*k +: 8];
            end
        end
        regs_d[0][0] = 1'b0;
        regs_d[1]    = status_in;
    end

    // Read decode and read channel FSM.
    always_comb begin
        if (ar_idx_s < IDX_W'(NUM_REGS)) begin
            rd_val_s = regs_q[ar_idx_s[SEL_W-1:0]];
            rd_err_s = 1'b0;
`ifdef AXILITE_SLV_DBG_CNT_EN
        end else if (ar_idx_s == IDX_W'(NUM_REGS)) begin
            rd_val_s = wr_cnt_q;
            rd_err_s = 1'b0;
        end else if (ar_idx_s == IDX_W'(NUM_REGS + 1)) begin
            rd_val_s = rd_cnt_q;
            rd_err_s = 1'b0;
`endif
        end else begin
            rd_val_s = 32'h0000_0000;
            rd_err_s = 1'b1;
        end
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val_s;
                    rresp_d   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and output flops.
    always_ff @(posedge clk_afu or posedge rst) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            awready_q    <= 1'b1;
            wready_q     <= 1'b1;
            aw_idx_q     <= '0;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'h0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            ctrl_start_q <= 1'b0;
            r_state_q    <= R_IDLE;
            arready_q    <= 1'b1;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            rresp_q      <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
            regs_q[0]    <= RST_VAL & 32'hFFFF_FFFE;
            regs_q[1]    <= 32'h0000_0000;
        end else begin
            w_state_q    <= w_state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            aw_idx_q     <= aw_idx_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            ctrl_start_q <= ctrl_start_d;
            r_state_q    <= r_state_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef AXILITE_SLV_DBG_CNT_EN
    logic [31:0] wr_cnt_d, rd_cnt_d;
    assign wr_cnt_d = wr_cnt_q + {31'h0, bvalid_q & s_axi_bready};
    assign rd_cnt_d = rd_cnt_q + {31'h0, rvalid_q & s_axi_rready};

    // Completed-response counters, including SLVERR responses.
    always_ff @(posedge clk_afu or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= 32'h0000_0000;
            rd_cnt_q <= 32'h0000_0000;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end
`endif

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign ctrl_start    = ctrl_start_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[32*g +: 32] = regs_q[g];
    end
endmodule

// File: tb/tb_axilite_slave_regs.sv
// Randomized self-checking bench for axilite_slave_regs against an array-based register model.
module tb_axilite_slave_regs;
    localparam int          ADDR_W   = 32;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] RST_VAL  = 32'h0000_0000;

    logic clk_afu, rst;
    logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
    logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready, ctrl_start;
    logic [ADDR_W-1:0] s_axi_awaddr, s_axi_araddr;
    logic [2:0] s_axi_awprot, s_axi_arprot;
    logic [31:0] s_axi_wdata, s_axi_rdata, status_in;
    logic [3:0] s_axi_wstrb;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic [NUM_REGS*32-1:0] regs_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_regs [NUM_REGS];
    logic [31:0] m_wr_cnt, m_rd_cnt;

    axilite_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RST_VAL(RST_VAL)) dut (
        .clk_afu(clk_afu), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awprot(s_axi_awprot), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .status_in(status_in), .ctrl_start(ctrl_start), .regs_out(regs_out)
    );

    initial clk_afu = 1'b0;
    always #5 clk_afu = ~clk_afu;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = RST_VAL;
        m_regs[0][0] = 1'b0;
        m_regs[1] = status_in;
        m_wr_cnt = 32'h0;
        m_rd_cnt = 32'h0;
    endfunction

    function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        r = 2'b10;
        if (idx < NUM_REGS) begin
            r = 2'b00;
            if (idx != 1)
                for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
            if (idx == 0) m_regs[0][0] = 1'b0;
        end
`ifdef AXILITE_SLV_DBG_CNT_EN
        if (idx == NUM_REGS || idx == NUM_REGS + 1) r = 2'b00;
`endif
        m_wr_cnt = m_wr_cnt + 32'h1;
        return r;
    endfunction

    task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        d = 32'h0;
        r = 2'b10;
        if (idx < NUM_REGS) begin
            d = m_regs[idx];
            r = 2'b00;
        end
`ifdef AXILITE_SLV_DBG_CNT_EN
        if (idx == NUM_REGS)     begin d = m_wr_cnt; r = 2'b00; end
        if (idx == NUM_REGS + 1) begin d = m_rd_cnt; r = 2'b00; end
`endif
        m_rd_cnt = m_rd_cnt + 32'h1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_afu);
        #1 rst = 1'b0;
        @(posedge clk_afu); #1;
        model_reset();
    endtask

    // Drives one write; reports bvalid cycle, response, start pulse and channel behaviour while bvalid waits.
    task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int hold,
                             output logic got_b, output int b_cyc, output logic [1:0] resp,
                             output logic start, output logic start_after, output logic stable_ok);
        logic aw_done, w_done, aw_fire, w_fire;
        int c;
        aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0; c = 0; b_cyc = 0;
        resp = 2'b00; start = 1'b0; start_after = 1'b0; stable_ok = 1'b1;
        s_axi_awaddr = {30'(idx), 2'($urandom_range(0, 3))};
        s_axi_awprot = 3'($urandom);
        s_axi_wdata = d;
        s_axi_wstrb = s;
        while (!got_b && c < 40) begin
            s_axi_awvalid = !aw_done && c >= aw_dly;
            s_axi_wvalid  = !w_done && c >= w_dly;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            @(posedge clk_afu); #1;
            c++;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            if (s_axi_bvalid) begin
                got_b = 1'b1; b_cyc = c; resp = s_axi_bresp; start = ctrl_start;
            end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        if (got_b) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_afu); #1;
                if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_wready || ctrl_start)
                    stable_ok = 1'b0;
            end
            s_axi_bready = 1'b1;
            @(posedge clk_afu); #1;
            s_axi_bready = 1'b0;
            start_after = ctrl_start;
            if (s_axi_bvalid || !s_axi_awready || !s_axi_wready) stable_ok = 1'b0;
        end
    endtask

    // Drives one read; while rvalid waits, offers another AR that must not be taken.
    task automatic axi_read(input int idx, input int hold, output logic got_r, output int r_cyc,
                            output logic [31:0] data, output logic [1:0] resp, output logic stable_ok);
        logic ar_done, ar_fire;
        int c;
        ar_done = 1'b0; got_r = 1'b0; c = 0; r_cyc = 0; data = 32'h0; resp = 2'b00; stable_ok = 1'b1;
        s_axi_araddr = {30'(idx), 2'($urandom_range(0, 3))};
        s_axi_arprot = 3'($urandom);
        while (!got_r && c < 40) begin
            s_axi_arvalid = !ar_done;
            ar_fire = s_axi_arvalid && s_axi_arready;
            @(posedge clk_afu); #1;
            c++;
            if (ar_fire) ar_done = 1'b1;
            if (s_axi_rvalid) begin
                got_r = 1'b1; r_cyc = c; data = s_axi_rdata; resp = s_axi_rresp;
            end
        end
        s_axi_arvalid = 1'b0;
        if (got_r) begin
            for (int h = 0; h < hold; h++) begin
                s_axi_arvalid = 1'b1;
                s_axi_araddr = 32'(($urandom_range(0, NUM_REGS - 1)) * 4);
                @(posedge clk_afu); #1;
                if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp || s_axi_arready)
                    stable_ok = 1'b0;
            end
            s_axi_arvalid = 1'b0;
            s_axi_rready = 1'b1;
            @(posedge clk_afu); #1;
            s_axi_rready = 1'b0;
            if (s_axi_rvalid || !s_axi_arready) stable_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic gr, ok; int rc; logic [31:0] rd, ed; logic [1:0] rr, er;
        rst = 1'b1;
        repeat (2) @(posedge clk_afu);
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, ctrl_start} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_handshake: got %b required 111000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, ctrl_start});
        end
        checks++;
        if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_resp_data: got %h required 0", {s_axi_bresp, s_axi_rresp, s_axi_rdata});
        end
        ed = RST_VAL;
        checks++;
        if (regs_out[31:0] !== (ed & 32'hFFFF_FFFE) || regs_out[63:32] !== 32'h0 || regs_out[95:64] !== ed) begin
            failures++;
            $display("FAIL reset_regs: got %h required ctrl=%h status=0 rw=%h", regs_out[95:0], ed & 32'hFFFF_FFFE, ed);
        end
        #1 rst = 1'b0;
        @(posedge clk_afu); #1;
        model_reset();
        for (int i = 2; i < NUM_REGS; i++) begin
            axi_read(i, 0, gr, rc, rd, rr, ok);
            model_read(i, ed, er);
            checks++;
            if (!gr || rc !== 1 || rd !== ed || rr !== er) begin
                failures++;
                $display("FAIL reset_read idx=%0d: got v=%0d lat=%0d data=%h resp=%b required lat=1 data=%h resp=%b",
                         i, gr, rc, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_strobe_order();
        logic gb, st, sa, ok, gr; int bc, rc; logic [1:0] br, er, rr; logic [31:0] rd, ed;
        for (int pass = 0; pass < 2; pass++) begin
            axi_write(2 + pass, 32'hDEAD_BEEF, 4'b0101, pass * 3, 3 - pass * 3, 0, gb, bc, br, st, sa, ok);
            er = model_write(2 + pass, 32'hDEAD_BEEF, 4'b0101);
            checks++;
            if (!gb || bc !== 4 || br !== er || !ok) begin
                failures++;
                $display("FAIL strobe_write pass=%0d: got v=%0d cyc=%0d resp=%b ok=%0d required cyc=4 resp=%b ok=1",
                         pass, gb, bc, br, ok, er);
            end
            axi_read(2 + pass, 0, gr, rc, rd, rr, ok);
            model_read(2 + pass, ed, er);
            checks++;
            if (!gr || rd !== ed || rd !== 32'h00AD_00EF || rr !== er) begin
                failures++;
                $display("FAIL strobe_read pass=%0d: got %h resp=%b required %h resp=%b", pass, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_ctrl_start();
        logic gb, st, sa, ok, gr; int bc, rc; logic [1:0] br, er, rr; logic [31:0] rd, ed;
        axi_write(0, 32'hA5A5_0001, 4'hF, 1, 0, 0, gb, bc, br, st, sa, ok);
        er = model_write(0, 32'hA5A5_0001, 4'hF);
        checks++;
        if (!gb || st !== 1'b1 || sa !== 1'b0 || br !== er) begin
            failures++;
            $display("FAIL ctrl_start_pulse: got v=%0d start=%b after=%b resp=%b required 1,0,%b", gb, st, sa, br, er);
        end
        axi_read(0, 0, gr, rc, rd, rr, ok);
        model_read(0, ed, er);
        checks++;
        if (!gr || rd !== ed || rd[0] !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_readback: got %h required %h", rd, ed);
        end
        axi_write(0, 32'h0000_1234, 4'hF, 0, 0, 0, gb, bc, br, st, sa, ok);
        er = model_write(0, 32'h0000_1234, 4'hF);
        checks++;
        if (!gb || st !== 1'b0) begin
            failures++;
            $display("FAIL ctrl_no_start: got start=%b required 0", st);
        end
    endtask

    task automatic test_out_of_range();
        logic gb, st, sa, ok, gr, bad; int bc, rc; logic [1:0] br, er, rr; logic [31:0] rd, ed;
        axi_write(NUM_REGS + 4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, gb, bc, br, st, sa, ok);
        er = model_write(NUM_REGS + 4, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (!gb || br !== 2'b10 || br !== er) begin
            failures++;
            $display("FAIL oor_bresp: got %b required %b", br, er);
        end
        bad = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) if (regs_out[32*i +: 32] !== m_regs[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL oor_regs_unchanged: got %h", regs_out);
        end
        axi_read(NUM_REGS + 4, 0, gr, rc, rd, rr, ok);
        model_read(NUM_REGS + 4, ed, er);
        checks++;
        if (!gr || rd !== 32'h0 || rr !== 2'b10 || rd !== ed || rr !== er) begin
            failures++;
            $display("FAIL oor_read: got %h resp=%b required 0 resp=10", rd, rr);
        end
    endtask

    task automatic test_hold();
        logic gb, st, sa, ok, gr; int bc, rc; logic [1:0] br, er, rr; logic [31:0] rd, ed, d;
        d = $urandom;
        axi_write(5, d, 4'hF, 0, 0, 10, gb, bc, br, st, sa, ok);
        er = model_write(5, d, 4'hF);
        checks++;
        if (!gb || !ok || br !== er) begin
            failures++;
            $display("FAIL hold_bvalid: got v=%0d stable=%0d resp=%b required 1,1,%b", gb, ok, br, er);
        end
        axi_read(5, 10, gr, rc, rd, rr, ok);
        model_read(5, ed, er);
        checks++;
        if (!gr || !ok || rd !== ed || rr !== er) begin
            failures++;
            $display("FAIL hold_rvalid: got v=%0d stable=%0d data=%h required 1,1,%h", gr, ok, rd, ed);
        end
    endtask

    task automatic test_same_cycle();
        logic gr, ok; int rc; logic [1:0] er, rr, wr; logic [31:0] rd, ed, d;
        d = $urandom;
        model_read(6, ed, er);
        s_axi_awaddr = {30'(6), 2'b00};
        s_axi_araddr = {30'(6), 2'b00};
        s_axi_wdata = d;
        s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(posedge clk_afu); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        checks++;
        if (!s_axi_rvalid || !s_axi_bvalid || s_axi_rdata !== ed) begin
            failures++;
            $display("FAIL same_cycle_pre: got r=%b b=%b data=%h required 1,1,%h", s_axi_rvalid, s_axi_bvalid, s_axi_rdata, ed);
        end
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        @(posedge clk_afu); #1;
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        wr = model_write(6, d, 4'hF);
        axi_read(6, 0, gr, rc, rd, rr, ok);
        model_read(6, ed, er);
        checks++;
        if (!gr || rd !== ed || rr !== er || wr !== 2'b00) begin
            failures++;
            $display("FAIL same_cycle_post: got %h required %h", rd, ed);
        end
    endtask

    task automatic test_random();
        logic gb, st, sa, ok, bad, exp_start; int bc, idx, awd, wd; logic [1:0] rr, er; logic [31:0] d, rd, ed;
        logic [3:0] s;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, NUM_REGS + 5);
            if ($urandom_range(0, 3) == 0) begin
                status_in = $urandom;
                @(posedge clk_afu); #1;
                m_regs[1] = status_in;
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom);
                awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
                exp_start = (idx == 0) && s[0] && d[0];
                axi_write(idx, d, s, awd, wd, 0, gb, bc, rr, st, sa, ok);
                er = model_write(idx, d, s);
                checks++;
                if (!gb || rr !== er || st !== exp_start || bc !== ((awd > wd ? awd : wd) + 1) || !ok) begin
                    failures++;
                    $display("FAIL rand_write n=%0d idx=%0d: got v=%0d resp=%b start=%b cyc=%0d ok=%0d required resp=%b start=%b cyc=%0d",
                             n, idx, gb, rr, st, bc, ok, er, exp_start, (awd > wd ? awd : wd) + 1);
                end
            end else begin
                axi_read(idx, $urandom_range(0, 2), gb, bc, rd, rr, ok);
                model_read(idx, ed, er);
                checks++;
                if (!gb || bc !== 1 || rd !== ed || rr !== er || !ok) begin
                    failures++;
                    $display("FAIL rand_read n=%0d idx=%0d: got %h resp=%b lat=%0d required %h resp=%b lat=1",
                             n, idx, rd, rr, bc, ed, er);
                end
            end
        end
        bad = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) if (regs_out[32*i +: 32] !== m_regs[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rand_regs_out: got %h", regs_out);
        end
    endtask

    task automatic test_reset_midtxn();
        logic bad;
        s_axi_awaddr = {30'(7), 2'b00};
        s_axi_awvalid = 1'b1;
        @(posedge clk_afu); #1;
        s_axi_awvalid = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if (!s_axi_awready || s_axi_bvalid || regs_out[32*7 +: 32] !== RST_VAL) begin
            failures++;
            $display("FAIL midtxn_async_reset: got awready=%b bvalid=%b r7=%h required 1,0,%h",
                     s_axi_awready, s_axi_bvalid, regs_out[32*7 +: 32], RST_VAL);
        end
        @(posedge clk_afu); #1 rst = 1'b0;
        @(posedge clk_afu); #1;
        model_reset();
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk_afu); #1;
            if (s_axi_bvalid || !s_axi_awready || !s_axi_wready) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midtxn_no_response: got bvalid=%b awready=%b required 0,1", s_axi_bvalid, s_axi_awready);
        end
    endtask

    task automatic test_dbg();
        logic gb, st, sa, ok; int bc; logic [1:0] rr, er; logic [31:0] rd, ed;
`ifdef AXILITE_SLV_DBG_CNT_EN
        do_reset();
        axi_write(2, 32'h1111_2222, 4'hF, 0, 1, 0, gb, bc, rr, st, sa, ok); er = model_write(2, 32'h1111_2222, 4'hF);
        axi_write(4, 32'h3333_4444, 4'hF, 2, 0, 0, gb, bc, rr, st, sa, ok); er = model_write(4, 32'h3333_4444, 4'hF);
        axi_write(NUM_REGS + 4, 32'h5, 4'hF, 0, 0, 0, gb, bc, rr, st, sa, ok); er = model_write(NUM_REGS + 4, 32'h5, 4'hF);
        axi_read(2, 0, gb, bc, rd, rr, ok); model_read(2, ed, er);
        axi_read(NUM_REGS + 4, 0, gb, bc, rd, rr, ok); model_read(NUM_REGS + 4, ed, er);
        axi_read(NUM_REGS, 0, gb, bc, rd, rr, ok); model_read(NUM_REGS, ed, er);
        checks++;
        if (!gb || rd !== 32'd3 || rd !== ed || rr !== 2'b00) begin
            failures++;
            $display("FAIL dbg_wr_cnt: got %0d resp=%b required 3 resp=00", rd, rr);
        end
        axi_read(NUM_REGS + 1, 0, gb, bc, rd, rr, ok); model_read(NUM_REGS + 1, ed, er);
        checks++;
        if (!gb || rd !== 32'd3 || rd !== ed || rr !== 2'b00) begin
            failures++;
            $display("FAIL dbg_rd_cnt: got %0d resp=%b required 3 resp=00", rd, rr);
        end
        axi_write(NUM_REGS, 32'hFFFF_0000, 4'hF, 0, 0, 0, gb, bc, rr, st, sa, ok); er = model_write(NUM_REGS, 32'hFFFF_0000, 4'hF);
        checks++;
        if (!gb || rr !== 2'b00 || rr !== er) begin
            failures++;
            $display("FAIL dbg_ro_write: got resp=%b required 00", rr);
        end
        axi_read(NUM_REGS, 0, gb, bc, rd, rr, ok); model_read(NUM_REGS, ed, er);
        checks++;
        if (!gb || rd !== ed) begin
            failures++;
            $display("FAIL dbg_wr_cnt_after: got %0d required %0d", rd, ed);
        end
`else
        axi_read(NUM_REGS, 0, gb, bc, rd, rr, ok); model_read(NUM_REGS, ed, er);
        checks++;
        if (!gb || rr !== 2'b10 || rd !== 32'h0 || rr !== er) begin
            failures++;
            $display("FAIL nodbg_read: got %h resp=%b required 0 resp=10", rd, rr);
        end
        axi_write(NUM_REGS + 1, 32'h1, 4'hF, 0, 0, 0, gb, bc, rr, st, sa, ok); er = model_write(NUM_REGS + 1, 32'h1, 4'hF);
        checks++;
        if (!gb || rr !== 2'b10 || rr !== er) begin
            failures++;
            $display("FAIL nodbg_write: got resp=%b required 10", rr);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_awprot = 3'b000; s_axi_arprot = 3'b000;
        s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        status_in = $urandom;
        test_reset();
        test_strobe_order();
        test_ctrl_start();
        test_out_of_range();
        test_hold();
        test_same_cycle();
        test_random();
        test_reset_midtxn();
        test_dbg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
